// File: rtl/api_spi_responder.sv
// -----------------------------------------------------------------------------
// api_spi_responder
//
// Extension-side endpoint of the API extension access port. Each access
// (cs held high by the initiator) becomes one 48-bit SPI mode-0 master frame
// to an off-chip register device: {opcode, address, data}, MSB first. When the
// frame is done, ready is raised and held until the initiator drops cs. This
// lets an SPI-attached peripheral sit in the API address space behind the
// normal wait/ready handshake.
//
// Parameters:
//   CLK_DIV      clk cycles per SCLK half-period (2..255)
//   READ_OPCODE  first frame byte for a read
//   WRITE_OPCODE first frame byte for a write
//
// Ports:
//   clk         system clock
//   reset       asynchronous reset, active low
//   cs          access request, held until ready is seen
//   we          1 = write, 0 = read (sampled with cs)
//   address     register address (sampled with cs)
//   write_data  write payload (sampled with cs)
//   read_data   read result, updated only by completed reads
//   ready       access complete
//   spi_sclk    SPI clock (mode 0, idles low)
//   spi_cs_n    SPI chip select, active low
//   spi_mosi    serial data out, MSB first
//   spi_miso    serial data in, MSB first
// -----------------------------------------------------------------------------
module api_spi_responder #(
    parameter int unsigned CLK_DIV      = 4,
    parameter logic [7:0]  READ_OPCODE  = 8'h03,
    parameter logic [7:0]  WRITE_OPCODE = 8'h02
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'd47;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_ctr_q, div_ctr_d;
    logic [5:0]  bit_ctr_q, bit_ctr_d;
    logic [47:0] shreg_q, shreg_d;
    logic        we_q, we_d;
    logic [31:0] read_data_q, read_data_d;
    logic        ready_q, ready_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;

    logic        div_last;
    logic [7:0]  opcode;

    assign div_last = (div_ctr_q == DIV_LAST);
    assign opcode   = we ? WRITE_OPCODE : READ_OPCODE;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            div_ctr_q   <= 8'd0;
            bit_ctr_q   <= 6'd0;
            shreg_q     <= 48'd0;
            we_q        <= 1'b0;
            read_data_q <= 32'd0;
            ready_q     <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_ctr_q   <= div_ctr_d;
            bit_ctr_q   <= bit_ctr_d;
            shreg_q     <= shreg_d;
            we_q        <= we_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cs)       state_d = S_SETUP;
            S_SETUP: if (div_last) state_d = S_SHIFT;
            // Leave SHIFT only at the end of the 48th high phase
            S_SHIFT: if (div_last && sclk_q && (bit_ctr_q == BIT_LAST)) state_d = S_HOLD;
            S_HOLD:  if (div_last) state_d = S_DONE;
            S_DONE:  if (!cs)      state_d = S_GAP;
            S_GAP:   if (div_last) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        div_ctr_d   = 8'd0;
        bit_ctr_d   = bit_ctr_q;
        shreg_d     = shreg_q;
        we_d        = we_q;
        read_data_d = read_data_q;
        ready_d     = ready_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;

        // Timed states share one divider that wraps every CLK_DIV cycles
        if ((state_q == S_SETUP) || (state_q == S_SHIFT) ||
            (state_q == S_HOLD)  || (state_q == S_GAP)) begin
            div_ctr_d = div_last ? 8'd0 : div_ctr_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (cs) begin
                    shreg_d   = {opcode, address, (we ? write_data : 32'd0)};
                    we_d      = we;
                    bit_ctr_d = 6'd0;
                    cs_n_d    = 1'b0;
                    mosi_d    = opcode[7];
                end
            end
            S_SHIFT: begin
                if (div_last) begin
                    if (!sclk_q) begin
                        // Rising SCLK: shift left, MISO enters at the LSB.
                        // After the shift, bit 47 already holds the next MOSI bit.
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[46:0], spi_miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_ctr_q == BIT_LAST) begin
                            mosi_d = 1'b0;
                        end else begin
                            bit_ctr_d = bit_ctr_q + 6'd1;
                            mosi_d    = shreg_q[47];
                        end
                    end
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    cs_n_d  = 1'b1;
                    ready_d = 1'b1;
                    // The last 32 sampled bits sit in the low word
                    if (!we_q) begin
                        read_data_d = shreg_q[31:0];
                    end
                end
            end
            S_DONE: begin
                if (!cs) begin
                    ready_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: doc/api_spi_responder.md
Name: api_spi_responder

Overview:
- Extension-side endpoint of the API extension access port (cs/we/address/write_data in; read_data/ready out).
- Turns each access into one SPI master frame to an off-chip register device, then reports completion on ready.
- Lets an SPI-attached peripheral appear in the API address space behind the existing wait/ready mechanism.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255.
- READ_OPCODE, 8'h03: first frame byte for a read.
- WRITE_OPCODE, 8'h02: first frame byte for a write.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; the block is in reset while this input is 0.
- cs  in  1  access request; held high by the initiator until ready is seen.
- we  in  1  1 = write, 0 = read; sampled with cs.
- address  in  8  register address; sampled with cs.
- write_data  in  32  write payload; sampled with cs.
- read_data  out  32  read result.
- ready  out  1  access complete.
- spi_sclk  out  1  SPI clock, mode 0.
- spi_cs_n  out  1  SPI chip select, active low.
- spi_mosi  out  1  serial data out, MSB first.
- spi_miso  in  1  serial data in, MSB first.

Behaviour:
- Reset values: read_data=0, ready=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0. All state and counters are cleared.
- Reset mid-frame: outputs return to the reset values immediately. No partial completion is reported.
- Registered outputs: all outputs are registered.
- ready is low in every state except DONE. It is therefore 0 on the cycle cs first rises, as the initiator's fixed 2-cycle wait requires.
- Frame format: 48 bits, MSB first.
  - Bits [47:40] = opcode (WRITE_OPCODE if we, else READ_OPCODE).
  - Bits [39:32] = address.
  - Bits [31:0] = write_data on writes, 0 on reads.
- Frame latching: opcode, address and write_data are latched into a 48-bit shift register on the IDLE->SETUP edge. Later changes on the inputs are ignored.
- FSM states:
  - IDLE: if cs=1, latch the frame and set spi_cs_n=0 and spi_mosi=bit47. Go to SETUP.
  - SETUP: hold for CLK_DIV cycles. Go to SHIFT.
  - SHIFT: 48 bits, each 2*CLK_DIV cycles.
    - Low phase CLK_DIV cycles, then high phase CLK_DIV cycles.
    - On the edge raising spi_sclk, sample spi_miso into the shift register LSB.
    - On the edge lowering spi_sclk, present the next MOSI bit.
    - After the 48th high phase, spi_sclk returns to 0. Go to HOLD.
  - HOLD: spi_cs_n stays low for CLK_DIV cycles, with spi_mosi=0.
    - Then set spi_cs_n=1 and ready=1.
    - On a read, load read_data with the last 32 sampled bits.
    - On a write, leave read_data unchanged.
    - Go to DONE.
  - DONE: hold ready=1 while cs=1. When cs=0, set ready=0 and go to GAP.
  - GAP: spi_cs_n stays high for CLK_DIV cycles. Go to IDLE. A cs held or re-raised during GAP is accepted in IDLE.
- Latency: cs is sampled high at edge N, so spi_cs_n falls at N. spi_cs_n rises and ready rises together at edge N + 98*CLK_DIV (392 cycles for CLK_DIV=4).
- Counters:
  - div_ctr is 8-bit, counts 0..CLK_DIV-1 and wraps.
  - bit_ctr is 6-bit, counts 0..47. SHIFT exits when bit_ctr=47 and the high phase ends.
- Boundary cases:
  - cs dropping during SETUP, SHIFT or HOLD: the frame completes. In DONE with cs already low, ready is a 1-cycle pulse.
  - we/address changes mid-frame: no effect.
  - Back-to-back accesses: at least CLK_DIV cycles of spi_cs_n high between frames.
  - CLK_DIV=2: exact 2-cycle half-periods.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → all outputs at reset values; no SCLK edges while cs=0.
- Write, CLK_DIV=4:
  - Stimulus: we=1, address=8'h12, write_data=32'hDEADBEEF.
  - MOSI sampled on 48 rising SCLK edges = 48'h0212DEADBEEF.
  - SCLK period 8 cycles; ready rises exactly 392 cycles after the edge sampling cs.
  - read_data unchanged.
- Read:
  - Stimulus: we=0, address=8'hA5; the slave model returns 16'h0000 then 32'h12345678 on MISO.
  - MOSI header = 8'h03, 8'hA5, then zeros.
  - read_data=32'h12345678 when ready=1.
  - ready falls 1 cycle after cs falls.
- API-extension-style handshake:
  - Stimulus: cs and we rise together and are held; ready is checked 2 cycles later.
  - ready=0 until DONE.
  - Drop cs → ready=0 next cycle; spi_cs_n stays high ≥4 cycles before the next frame starts.
- Reset mid-frame: assert reset=0 at bit 20 of SHIFT → spi_cs_n=1 and spi_sclk=0 immediately, ready=0; the next access runs a full, correct 48-bit frame.
- Early cs drop plus CLK_DIV=2: drop cs during SETUP → the full frame still runs, ready is a 1-cycle pulse, and the SCLK half-period is 2 cycles.
